// File: rtl/vdcm_pix_pkg.sv
// Shared definitions for the VDCM pixel output path.
package vdcm_pix_pkg;

    localparam int unsigned BPC_DEFAULT  = 14;
    localparam int unsigned PIX_PER_WORD = 4;
    localparam int unsigned COMP_PER_PIX = 3;

    // pixs_per_clk encodings
    typedef enum logic [1:0] {
        PPC_1     = 2'd0,
        PPC_2     = 2'd1,
        PPC_4     = 2'd2,
        PPC_4_ALT = 2'd3
    } ppc_e;

    // log2 of the pixels emitted per beat; the spare encoding behaves as 4
    function automatic logic [1:0] rate_shift(input logic [1:0] ppc);
        logic [1:0] sh;
        case (ppc)
            PPC_1:   sh = 2'd0;
            PPC_2:   sh = 2'd1;
            default: sh = 2'd2;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/pix_word_fifo.sv
// Single-clock word FIFO with combinational head, flush and occupancy.
module pix_word_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 168
) (
    input  logic                     clk_out_int,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    // full is judged on the registered count, before any same-cycle pop
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];
    assign do_wr   = wr_en && !full && !flush;
    assign do_rd   = rd_en && !empty && !flush;

    // storage array, no reset needed
    always_ff @(posedge clk_out_int) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // pointers and occupancy
    always_ff @(posedge clk_out_int) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pix_out_serializer.sv
// Buffers 4-pixel words and serializes them into 1/2/4-pixel beats with frame position flags.
module pix_out_serializer
    import vdcm_pix_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BPC        = BPC_DEFAULT
) (
    input  logic                                   clk_out_int,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic [1:0]                             pixs_per_clk,
    input  logic [15:0]                            frame_width,
    input  logic [15:0]                            frame_height,
    input  logic [PIX_PER_WORD*COMP_PER_PIX*BPC-1:0] pixs_in,
    input  logic                                   pixs_in_valid,
    input  logic                                   out_ready,
    output logic [PIX_PER_WORD*COMP_PER_PIX*BPC-1:0] pixs_out,
    output logic                                   pixs_out_valid,
    output logic                                   pixs_out_sof,
    output logic                                   pixs_out_sol,
    output logic                                   pixs_out_eol,
    output logic                                   pixs_out_eof,
    output logic                                   overflow,
    output logic [$clog2(FIFO_DEPTH):0]            fifo_level
);

    localparam int unsigned PIX_W  = COMP_PER_PIX * BPC;
    localparam int unsigned WORD_W = PIX_PER_WORD * PIX_W;

    logic [1:0]        rate_q;
    logic [1:0]        beat_idx;
    logic [15:0]       x_q;
    logic [15:0]       y_q;

    logic [WORD_W-1:0] head_word;
    logic              fifo_full;
    logic              fifo_empty;

    logic [PIX_W-1:0]  head_pix [PIX_PER_WORD];
    logic [1:0]        rate_sh_c;
    logic [2:0]        rate_pix_c;
    logic [1:0]        base_c;
    logic              last_beat_c;
    logic              accept_c;
    logic              load_c;
    logic              pop_c;
    logic [16:0]       x_sum_c;
    logic              line_end_c;
    logic              frame_end_c;
    logic [15:0]       x_nxt_c;
    logic [15:0]       y_nxt_c;
    logic [15:0]       pos_x_c;
    logic [15:0]       pos_y_c;
    logic [16:0]       pos_sum_c;
    logic              sol_c;
    logic              eol_c;
    logic              sof_c;
    logic              eof_c;
    logic [WORD_W-1:0] lanes_c;

    pix_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk_out_int (clk_out_int),
        .rst         (rst),
        .flush       (flush),
        .wr_en       (pixs_in_valid),
        .wr_data     (pixs_in),
        .rd_en       (pop_c),
        .rd_data     (head_word),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .level       (fifo_level)
    );

    // beat sequencing and lane selection for the head word
    always_comb begin
        rate_sh_c   = rate_shift(rate_q);
        rate_pix_c  = 3'(3'd1 << rate_sh_c);
        base_c      = 2'(beat_idx << rate_sh_c);
        accept_c    = pixs_out_valid && out_ready;
        load_c      = !fifo_empty && (!pixs_out_valid || out_ready);
        case (rate_sh_c)
            2'd0:    last_beat_c = (beat_idx == 2'd3);
            2'd1:    last_beat_c = (beat_idx == 2'd1);
            default: last_beat_c = 1'b1;
        endcase
        pop_c = load_c && last_beat_c;

        lanes_c = '0;
        for (int p = 0; p < PIX_PER_WORD; p++) begin
            head_pix[p] = head_word[p*PIX_W +: PIX_W];
        end
        for (int k = 0; k < PIX_PER_WORD; k++) begin
            if (3'(k) < rate_pix_c) begin
                lanes_c[k*PIX_W +: PIX_W] = head_pix[base_c + 2'(k)];
            end
        end
    end

    // x/y hold the position of the oldest unaccepted beat; derive the loaded beat's flags
    always_comb begin
        x_sum_c     = {1'b0, x_q} + 17'(rate_pix_c);
        line_end_c  = (x_sum_c >= {1'b0, frame_width});
        frame_end_c = (({1'b0, y_q} + 17'd1) >= {1'b0, frame_height});
        x_nxt_c     = line_end_c ? 16'd0 : x_sum_c[15:0];
        y_nxt_c     = y_q;
        if (line_end_c) begin
            y_nxt_c = frame_end_c ? 16'd0 : (y_q + 16'd1);
        end

        pos_x_c   = accept_c ? x_nxt_c : x_q;
        pos_y_c   = accept_c ? y_nxt_c : y_q;
        pos_sum_c = {1'b0, pos_x_c} + 17'(rate_pix_c);
        sol_c     = (pos_x_c == 16'd0);
        eol_c     = (pos_sum_c >= {1'b0, frame_width});
        sof_c     = sol_c && (pos_y_c == 16'd0);
        eof_c     = eol_c && (({1'b0, pos_y_c} + 17'd1) == {1'b0, frame_height});
    end

    // output register, position counters, rate capture and overflow
    always_ff @(posedge clk_out_int) begin
        if (rst || flush) begin
            rate_q         <= pixs_per_clk;
            beat_idx       <= '0;
            x_q            <= '0;
            y_q            <= '0;
            pixs_out_valid <= 1'b0;
            pixs_out_sof   <= 1'b0;
            pixs_out_sol   <= 1'b0;
            pixs_out_eol   <= 1'b0;
            pixs_out_eof   <= 1'b0;
            overflow       <= 1'b0;
            if (rst) begin
                pixs_out <= '0;
            end
        end else begin
            if (pixs_in_valid && fifo_full) begin
                overflow <= 1'b1;
            end
            if (accept_c) begin
                x_q <= x_nxt_c;
                y_q <= y_nxt_c;
            end
            if (load_c) begin
                pixs_out       <= lanes_c;
                pixs_out_valid <= 1'b1;
                pixs_out_sof   <= sof_c;
                pixs_out_sol   <= sol_c;
                pixs_out_eol   <= eol_c;
                pixs_out_eof   <= eof_c;
                beat_idx       <= last_beat_c ? 2'd0 : (beat_idx + 2'd1);
            end else if (accept_c) begin
                pixs_out_valid <= 1'b0;
                pixs_out_sof   <= 1'b0;
                pixs_out_sol   <= 1'b0;
                pixs_out_eol   <= 1'b0;
                pixs_out_eof   <= 1'b0;
            end
        end
    end

endmodule
